// File: rtl/crc32_pkg.sv
// Shared CRC-32 (Ethernet, reflected) constants, types and the single-byte update.
package crc32_pkg;

  typedef logic [31:0] crc32_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } crc_fsm_e;

  localparam crc32_t CRC32_POLY_REFL = 32'hEDB88320;
  localparam crc32_t CRC32_INIT      = 32'hFFFFFFFF;
  localparam crc32_t CRC32_RESIDUE   = 32'hDEBB20E3;

  // Eight LSB-first shift steps of the reflected LFSR for one wire byte.
  function automatic crc32_t crc32_byte(input crc32_t crc, input logic [7:0] data);
    crc32_t c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane_step.sv
// Combinational CRC-32 update over one beat: lane 0 first, result cut at the last kept lane.
module crc32_lane_step
  import crc32_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  crc32_t              crc_in,
  input  logic [DATA_W-1:0]   data,
  input  logic [KEEP_W-1:0]   keep,
  output crc32_t              crc_out
);

  logic [KEEP_W*32-1:0] lane_crc;

  for (genvar i = 0; i < KEEP_W; i++) begin : g_lane
    crc32_t c;
    if (i == 0) begin : g_first
      assign c = crc32_byte(crc_in, data[7:0]);
    end else begin : g_next
      assign c = crc32_byte(g_lane[i-1].c, data[8*i +: 8]);
    end
    assign lane_crc[32*i +: 32] = c;
  end

  // keep is contiguous from lane 0, so the highest set lane marks the last byte folded in.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep[i]) crc_out = lane_crc[32*i +: 32];
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine: framed valid/ready beats in, registered FCS per frame out.
// Define CRC32_CHECK_EN to also register a residue pass flag (res_ok) with each result.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_sof,
  input  logic              s_eof,
  output logic [31:0]       crc_state,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_crc,
  output logic              res_ok,
  output logic [CNT_W-1:0]  drop_cnt
);

  crc_fsm_e          state;
  crc32_t            lfsr;
  crc32_t            lfsr_next;
  crc32_t            step_base;
  logic [KEEP_W-1:0] lane_keep;
  logic              accept;
  logic              in_frame;
  logic              drop;

  assign s_ready   = !res_valid || res_ready;
  assign accept    = s_valid && s_ready;
  assign in_frame  = s_sof || (state == ST_ACCUM);
  // A stray beat in IDLE or a restart inside a frame both count as one discarded beat.
  assign drop      = accept && (s_sof ? (state == ST_ACCUM) : (state == ST_IDLE));
  assign step_base = s_sof ? CRC32_INIT : lfsr;
  assign lane_keep = s_eof ? s_keep : {KEEP_W{1'b1}};
  assign crc_state = lfsr;

  crc32_lane_step #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_step (
    .crc_in  (step_base),
    .data    (s_data),
    .keep    (lane_keep),
    .crc_out (lfsr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= CRC32_INIT;
      res_valid <= 1'b0;
      res_crc   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
      // An EOF here overrides the handshake clear above, giving back-to-back results.
      if (accept && in_frame) begin
        if (s_eof) begin
          state     <= ST_IDLE;
          lfsr      <= CRC32_INIT;
          res_valid <= 1'b1;
          res_crc   <= ~lfsr_next;
        end else begin
          state <= ST_ACCUM;
          lfsr  <= lfsr_next;
        end
      end
    end
  end

`ifdef CRC32_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ok <= 1'b0;
    end else if (accept && in_frame && s_eof) begin
      res_ok <= (lfsr_next == CRC32_RESIDUE);
    end
  end
`else
  assign res_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// Self-checking bench for crc32_stream (32-bit beats, 4-bit drop counter) against a bit-serial CRC model.
module tb_crc32_stream;

  localparam int DATA_W = 32;
  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef logic [7:0] byteq_t[$];

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [KEEP_W-1:0] s_keep;
  logic              s_sof;
  logic              s_eof;
  logic [31:0]       crc_state;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_crc;
  logic              res_ok;
  logic [CNT_W-1:0]  drop_cnt;

  int  tests = 0;
  int  fails = 0;
  bit  rand_bp = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  crc32_stream #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_sof     (s_sof),
    .s_eof     (s_eof),
    .crc_state (crc_state),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_crc   (res_crc),
    .res_ok    (res_ok),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  // Every completed result handshake is logged; the handshake edge follows this negedge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) got_q.push_back(res_crc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: raw register after shifting every wire bit LSB-first through the reflected polynomial.
  function automatic logic [31:0] crc_raw(input byteq_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[n]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[n][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic sof, input logic eof);
    int n;
    s_data  = d;
    s_keep  = k;
    s_sof   = sof;
    s_eof   = eof;
    s_valid = 1'b1;
    if (rand_bp) res_ready = ($urandom_range(0, 1) != 0);
    #1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk);
      #1;
      if (rand_bp) res_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (n >= 200) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input byteq_t fb);
    int          pos;
    int          cnt;
    logic [31:0] d;
    logic [3:0]  k;
    byteq_t      pre;
    pos = 0;
    while (pos < fb.size()) begin
      cnt = (fb.size() - pos >= 4) ? 4 : fb.size() - pos;
      d   = $urandom;
      k   = 4'b0000;
      for (int i = 0; i < cnt; i++) begin
        d[8*i +: 8] = fb[pos+i];
        k[i]        = 1'b1;
        pre.push_back(fb[pos+i]);
      end
      send_beat(d, k, pos == 0, pos + cnt == fb.size());
      pos += cnt;
      if (pos < fb.size()) check("crc_state_mid", crc_state, crc_raw(pre));
    end
    exp_q.push_back(~crc_raw(fb));
  endtask

  task automatic drain_compare(input string tag);
    int n;
    res_ready = 1'b1;
    #1;
    n = 0;
    while (res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check({tag, "_crc"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic byteq_t rand_bytes(input int len);
    byteq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    byteq_t      ascii;
    byteq_t      fr;
    byteq_t      fr2;
    logic [31:0] hold;
    logic [CNT_W-1:0] dc;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_sof = 1'b0; s_eof = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_crc_state", crc_state, 32'hFFFFFFFF);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_crc", res_crc, 32'd0);
    check("rst_res_ok", 32'(res_ok), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    // Check string, last beat carries one kept byte plus junk lanes.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(ascii);
    check("check_str_valid", 32'(res_valid), 32'd1);
    check("check_str_crc", res_crc, 32'hCBF43926);

    // Frame that carries its own FCS, then the same with one bit flipped.
    fr = ascii;
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    send_frame(fr);
`ifdef CRC32_CHECK_EN
    check("residue_ok", 32'(res_ok), 32'd1);
`else
    check("residue_tied", 32'(res_ok), 32'd0);
`endif
    fr[2] = fr[2] ^ 8'h10;
    send_frame(fr);
    check("residue_bad", 32'(res_ok), 32'd0);

    // EOF beat with no kept lanes folds nothing.
    fr = rand_bytes(4);
    send_beat({fr[3], fr[2], fr[1], fr[0]}, 4'hF, 1'b1, 1'b0);
    send_beat($urandom, 4'h0, 1'b0, 1'b1);
    exp_q.push_back(~crc_raw(fr));
    check("keep0_crc", res_crc, ~crc_raw(fr));
    drain_compare("directed");

    // Result backpressure.
    res_ready = 1'b0;
    fr = rand_bytes(7);
    send_frame(fr);
    for (int i = 0; i < 5; i++) begin
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_res_crc", res_crc, ~crc_raw(fr));
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(res_valid), 32'd0);

    // Back-to-back frames: the second EOF lands on the first result's handshake.
    fr  = rand_bytes(8);
    fr2 = rand_bytes(3);
    send_frame(fr);
    check("b2b_first_valid", 32'(res_valid), 32'd1);
    check("b2b_first_crc", res_crc, ~crc_raw(fr));
    send_frame(fr2);
    check("b2b_second_valid", 32'(res_valid), 32'd1);
    check("b2b_second_crc", res_crc, ~crc_raw(fr2));
    drain_compare("b2b");

    // Beats without SOF in IDLE are dropped and produce no result.
    for (int i = 0; i < 3; i++) send_beat($urandom, 4'hF, 1'b0, i == 2);
    check("idle_drop_cnt", 32'(drop_cnt), 32'd3);
    check("idle_drop_no_res", 32'(res_valid), 32'd0);

    // SOF inside a frame restarts it; only the restarted frame is reported.
    send_beat($urandom, 4'hF, 1'b1, 1'b0);
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    fr = rand_bytes(6);
    send_frame(fr);
    check("abort_drop_cnt", 32'(drop_cnt), 32'd4);
    check("abort_crc", res_crc, ~crc_raw(fr));
    drain_compare("abort");

    // Saturation of the drop counter.
    for (int i = 0; i < 11; i++) send_beat($urandom, 4'hF, 1'b0, 1'b0);
    check("drop_full", 32'(drop_cnt), 32'd15);
    dc = drop_cnt;
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    check("drop_saturate", 32'(drop_cnt), 32'(dc));
    check("drop_saturate_ones", 32'(drop_cnt), 32'd15);

    // Asynchronous reset in the middle of a frame.
    fr = rand_bytes(4);
    send_beat({fr[3], fr[2], fr[1], fr[0]}, 4'hF, 1'b1, 1'b0);
    check("pre_rst_state", crc_state, crc_raw(fr));
    rst = 1'b1;
    #1;
    check("midrst_crc_state", crc_state, 32'hFFFFFFFF);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fr = rand_bytes(10);
    send_frame(fr);
    check("post_rst_crc", res_crc, ~crc_raw(fr));
    drain_compare("post_rst");

    // Random frames under random result backpressure.
    rand_bp = 1'b1;
    for (int f = 0; f < 30; f++) begin
      fr = rand_bytes($urandom_range(1, 20));
      send_frame(fr);
      if ($urandom_range(0, 3) == 0) begin
        hold = $urandom_range(1, 3);
        repeat (hold) @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    drain_compare("random");
    check("final_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
